// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM states,
// forwarding-select encodings and the shadow record kept per stage.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef struct packed {
    logic [4:0] rd;
    logic       rfwe;
    logic       is_load;
  } shadow_t;

  localparam shadow_t BUBBLE = shadow_t'(7'd0);

  // A stage produces a value for register r only if it really writes a
  // non-zero destination equal to r.
  function automatic logic is_producer(input logic [4:0] stage_rd,
                                       input logic       stage_rfwe,
                                       input logic [4:0] r);
    return stage_rfwe && (stage_rd != 5'd0) && (stage_rd == r);
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Per-source comparison of one ID source register against the EX, MEM and
// WB shadow records: youngest-producer forwarding select and hazard flags.
module hazard_cmp
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       rs_used,
  input  logic [4:0] ex_rd,
  input  logic       ex_rfwe,
  input  logic       ex_is_load,
  input  logic [4:0] mem_rd,
  input  logic       mem_rfwe,
  input  logic [4:0] wb_rd,
  input  logic       wb_rfwe,
  output logic [1:0] fwd_sel,
  output logic       raw_hit,
  output logic       lu_hit
);

  logic hit_ex;
  logic hit_mem;
  logic hit_wb;

  // Match against each stage; the youngest producer wins the forward select.
  always_comb begin
    hit_ex  = rs_used && is_producer(ex_rd, ex_rfwe, rs);
    hit_mem = rs_used && is_producer(mem_rd, mem_rfwe, rs);
    hit_wb  = rs_used && is_producer(wb_rd, wb_rfwe, rs);
    fwd_sel = FWD_RF;
    if (hit_ex) begin
      fwd_sel = FWD_EX;
    end else if (hit_mem) begin
      fwd_sel = FWD_MEM;
    end else if (hit_wb) begin
      fwd_sel = FWD_WB;
    end
    raw_hit = hit_ex || hit_mem || hit_wb;
    lu_hit  = hit_ex && ex_is_load;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: tracks EX/MEM/WB destination shadows, and
// produces stall, flush and forwarding controls with zero-cycle latency.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int FWD_EN      = 1,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0]             ID_rs1,
  input  logic [4:0]             ID_rs2,
  input  logic                   ID_rs1_used,
  input  logic                   ID_rs2_used,
  input  logic [4:0]             ID_rd,
  input  logic                   ID_rfwe,
  input  logic                   ID_is_load,
  input  logic                   EX_br_taken,
  input  logic                   mem_busy,
  output logic                   pc_stall,
  output logic                   IF_ID_stall,
  output logic                   ID_EX_stall,
  output logic                   EX_MEM_stall,
  output logic                   MEM_WB_stall,
  output logic                   IF_ID_flush,
  output logic                   ID_EX_flush,
  output logic [1:0]             fwd1_sel,
  output logic [1:0]             fwd2_sel,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  hz_state_t state_q;
  hz_state_t state_d;
  hz_state_t ctx_q;
  hz_state_t eval_state;
  shadow_t   ex_sh;
  shadow_t   mem_sh;
  shadow_t   wb_sh;

  logic [1:0] cmp1_fwd;
  logic [1:0] cmp2_fwd;
  logic       raw1;
  logic       raw2;
  logic       lu1;
  logic       lu2;
  logic       load_use;
  logic       hazard_stall;
  logic       unused_load_bits;

  assign unused_load_bits = mem_sh.is_load ^ wb_sh.is_load;

  hazard_cmp u_cmp_rs1 (
    .rs         (ID_rs1),
    .rs_used    (ID_rs1_used),
    .ex_rd      (ex_sh.rd),
    .ex_rfwe    (ex_sh.rfwe),
    .ex_is_load (ex_sh.is_load),
    .mem_rd     (mem_sh.rd),
    .mem_rfwe   (mem_sh.rfwe),
    .wb_rd      (wb_sh.rd),
    .wb_rfwe    (wb_sh.rfwe),
    .fwd_sel    (cmp1_fwd),
    .raw_hit    (raw1),
    .lu_hit     (lu1)
  );

  hazard_cmp u_cmp_rs2 (
    .rs         (ID_rs2),
    .rs_used    (ID_rs2_used),
    .ex_rd      (ex_sh.rd),
    .ex_rfwe    (ex_sh.rfwe),
    .ex_is_load (ex_sh.is_load),
    .mem_rd     (mem_sh.rd),
    .mem_rfwe   (mem_sh.rfwe),
    .wb_rd      (wb_sh.rd),
    .wb_rfwe    (wb_sh.rfwe),
    .fwd_sel    (cmp2_fwd),
    .raw_hit    (raw2),
    .lu_hit     (lu2)
  );

  // Control outputs and next state, in priority order reset > mem_busy >
  // taken branch > load-use/RAW stall > forwarding.
  always_comb begin
    pc_stall     = 1'b0;
    IF_ID_stall  = 1'b0;
    ID_EX_stall  = 1'b0;
    EX_MEM_stall = 1'b0;
    MEM_WB_stall = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    fwd1_sel     = FWD_RF;
    fwd2_sel     = FWD_RF;
    state_d      = state_q;
    eval_state   = (state_q == MEM_WAIT) ? ctx_q : state_q;
    load_use     = lu1 || lu2;
    hazard_stall = load_use || ((FWD_EN == 0) && (raw1 || raw2));

    if (!rst_n) begin
      state_d = RUN;
    end else begin
      if (FWD_EN != 0) begin
        fwd1_sel = cmp1_fwd;
        fwd2_sel = cmp2_fwd;
      end
      if (mem_busy) begin
        pc_stall     = 1'b1;
        IF_ID_stall  = 1'b1;
        ID_EX_stall  = 1'b1;
        EX_MEM_stall = 1'b1;
        MEM_WB_stall = 1'b1;
        state_d      = MEM_WAIT;
      end else begin
        if (EX_br_taken) begin
          IF_ID_flush = 1'b1;
          ID_EX_flush = 1'b1;
        end else if (hazard_stall) begin
          pc_stall    = 1'b1;
          IF_ID_stall = 1'b1;
          ID_EX_flush = 1'b1;
        end
        case (eval_state)
          LU_STALL: state_d = RUN;
          default:  state_d = (load_use && !EX_br_taken) ? LU_STALL : RUN;
        endcase
      end
    end
  end

  // FSM state plus the context to resume once memory stops being busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      ctx_q   <= RUN;
    end else begin
      state_q <= state_d;
      if (mem_busy && (state_q != MEM_WAIT)) begin
        ctx_q <= state_q;
      end
    end
  end

  // Shadow records advance one stage per cycle; a flush puts a bubble in EX.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_sh  <= BUBBLE;
      mem_sh <= BUBBLE;
      wb_sh  <= BUBBLE;
    end else if (!mem_busy) begin
      wb_sh  <= mem_sh;
      mem_sh <= ex_sh;
      ex_sh  <= ID_EX_flush ? BUBBLE :
                '{rd: ID_rd, rfwe: ID_rfwe, is_load: ID_is_load};
    end
  end

  // Performance counter of cycles in which the PC is held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (pc_stall) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter FWD_EN, default 1; 1 = resolve RAW by forwarding, 0 = resolve every RAW by stalling.
REQ-002 SHALL have parameter STALL_CNT_W, default 32; width of the stall performance counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port ID_rs1 / ID_rs2, input, 5 each, source register indices of the instruction in ID.
REQ-006 SHALL have port ID_rs1_used / ID_rs2_used, input, 1 each, high when the ID instruction reads that source.
REQ-007 SHALL have port ID_rd, input, 5, destination index of the ID instruction.
REQ-008 SHALL have port ID_rfwe, input, 1, ID instruction writes the register file.
REQ-009 SHALL have port ID_is_load, input, 1, ID instruction is a load (wdsel = DM).
REQ-010 SHALL have port EX_br_taken, input, 1, branch/jump in EX resolved taken.
REQ-011 SHALL have port mem_busy, input, 1, data memory not ready; the whole pipeline must freeze.
REQ-012 SHALL have ports pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_stall, outputs, 1 each, hold the corresponding register.
REQ-013 SHALL have ports IF_ID_flush and ID_EX_flush, outputs, 1 each, load a bubble (all controls 0) into that register.
REQ-014 SHALL have ports fwd1_sel and fwd2_sel, outputs, 2 each; 0 = RF, 1 = EX ALU result, 2 = MEM result, 3 = WB data.
REQ-015 SHALL have port stall_cnt, output, STALL_CNT_W, count of cycles with pc_stall high.

Function
REQ-016 SHALL keep a shadow record {rd, rfwe, is_load} for each of the EX, MEM and WB stages, advancing ID->EX->MEM->WB each cycle unless frozen.
REQ-017 SHALL treat a register with rd = 0 or rfwe = 0 as never producing a hazard.
REQ-018 SHALL compute hazards combinationally from ID inputs and the shadows, with zero-cycle latency to every control output.
REQ-019 SHALL detect load-use when a used ID source equals the EX rd and the EX shadow has is_load = 1; the response is one stall cycle: pc_stall = IF_ID_stall = 1, ID_EX_flush = 1.
REQ-020 SHALL select forwarding when FWD_EN = 1, giving EX priority over MEM and MEM priority over WB; with no match the select is 0.
REQ-021 SHALL, when FWD_EN = 0, stall as in REQ-019 while any used source matches the EX, MEM or WB rd, and SHALL hold fwd*_sel at 0.
REQ-022 SHALL use FSM states RUN, LU_STALL and MEM_WAIT.
REQ-023 SHALL move RUN->LU_STALL on a load-use hazard, return LU_STALL->RUN after one cycle, and re-evaluate hazards in RUN.
REQ-024 SHALL move to MEM_WAIT from any state when mem_busy = 1, and return to RUN on the first cycle with mem_busy = 0.
REQ-025 SHALL, in MEM_WAIT, assert all five stall outputs, assert no flushes, and freeze the shadows and the FSM return context.
REQ-026 SHALL, on EX_br_taken = 1 without mem_busy, assert IF_ID_flush = ID_EX_flush = 1, cancel any load-use stall, and keep pc_stall = 0.
REQ-027 SHALL resolve simultaneous events in priority order mem_busy > EX_br_taken > load-use/RAW stall > forwarding.
REQ-028 SHALL write a bubble into the EX shadow whenever ID_EX_flush is asserted.
REQ-029 SHALL increment stall_cnt on each cycle with pc_stall = 1, wrapping modulo 2^STALL_CNT_W.

Reset
REQ-030 SHALL, while rst_n = 0 at a clk edge, set the FSM to RUN, clear all shadows to bubbles, and clear stall_cnt to 0.
REQ-031 SHALL drive all stall and flush outputs to 0 and fwd*_sel to 0 during reset, including reset asserted mid-stall or mid-MEM_WAIT.

Structure
REQ-032 SHALL place the FSM state enum, the fwd_sel encodings (RF/EX/MEM/WB) and the bubble record constant in the shared pipeline package.
REQ-033 SHALL implement the per-source forwarding/hazard comparison as one sub-module, hazard_cmp, instantiated twice (rs1, rs2).

Verification
REQ-034 SHALL cover: load x5 in EX, ID uses rs1 = x5 -> exactly one cycle with pc_stall = 1 and ID_EX_flush = 1, then fwd1_sel = 2, stall_cnt = 1.
REQ-035 SHALL cover: ALU writing x7 in EX, ID rs2 = x7, FWD_EN = 1 -> fwd2_sel = 1, no stall.
REQ-036 SHALL cover: rd = x0 with rfwe = 1 in EX, ID rs1 = x0 -> fwd1_sel = 0, no stall.
REQ-037 SHALL cover: EX_br_taken = 1 in the same cycle as a load-use -> both flushes = 1, pc_stall = 0, state stays RUN.
REQ-038 SHALL cover: mem_busy = 1 for 3 cycles during LU_STALL -> all stalls = 1 for 3 cycles, then the pending behaviour resumes, stall_cnt = 4.
REQ-039 SHALL cover: FWD_EN = 0, writer in MEM, ID rs1 match -> stall until the writer leaves WB (2 cycles), fwd1_sel = 0 throughout.
